// File: rtl/scale_frame_seq.sv
// Frame sequencer for a pixel scaler: steps through a range of convert modes,
// holding the scaler in reset before each frame and checking pixel count and sum.
module scale_frame_seq #(
   parameter int PIX_W        = 16,
   parameter int FRAME_CYCLES = 65536,
   parameter int DUT_RST_CYC  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       mode_first,
   input  logic [3:0]       mode_last,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_valid,
   output logic             dut_rst_n,
   output logic [3:0]       convert_type,
   output logic             busy,
   output logic             frame_done,
   output logic [3:0]       frame_mode,
   output logic [16:0]      frame_count,
   output logic [31:0]      frame_sum,
   output logic             frame_err,
   output logic [7:0]       err_total,
   output logic             seq_done
);

   typedef enum logic [2:0] {S_IDLE, S_DRST, S_RUN, S_REPORT, S_DONE} state_t;

   localparam int CYC_MAX = (FRAME_CYCLES > DUT_RST_CYC) ? FRAME_CYCLES : DUT_RST_CYC;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(FRAME_CYCLES - 1);
   localparam logic [CYC_W-1:0] DRST_LAST = CYC_W'(DUT_RST_CYC - 1);
   localparam logic [16:0]      CNT_MAX   = '1;

   function automatic logic [16:0] expected_count(input logic [3:0] mode);
      case (mode)
         4'd0:    return 17'd36864;
         4'd1:    return 17'd16384;
         4'd2:    return 17'd9216;
         4'd3:    return 17'd4096;
         default: return 17'd65536;
      endcase
   endfunction

   // Modes 8..14 are reserved; anything landing there moves on to 15.
   function automatic logic [3:0] skip_reserved(input logic [3:0] mode);
      return (mode >= 4'd8 && mode <= 4'd14) ? 4'd15 : mode;
   endfunction

   state_t           r_state;
   logic [CYC_W-1:0] r_cyc;
   logic [16:0]      r_cnt;
   logic [31:0]      r_sum;
   logic [3:0]       r_mode_last;
   logic             r_dut_rst_n;
   logic [3:0]       r_convert_type;
   logic             r_busy;
   logic             r_frame_done;
   logic [3:0]       r_frame_mode;
   logic [16:0]      r_frame_count;
   logic [31:0]      r_frame_sum;
   logic             r_frame_err;
   logic [7:0]       r_err_total;
   logic             r_seq_done;

   logic [16:0] w_cnt_nxt;
   logic [31:0] w_sum_nxt;
   logic [3:0]  w_first_eff;
   logic [3:0]  w_next_mode;
   logic        w_last_frame;
   logic        w_frame_err;

   // The final RUN cycle's beat must be folded into the reported totals.
   assign w_cnt_nxt    = (pix_valid && r_cnt != CNT_MAX) ? r_cnt + 17'd1 : r_cnt;
   assign w_sum_nxt    = pix_valid ? r_sum + 32'(pix_data) : r_sum;
   assign w_first_eff  = skip_reserved(mode_first);
   assign w_next_mode  = skip_reserved(r_convert_type + 4'd1);
   assign w_last_frame = (r_convert_type == r_mode_last) || (r_convert_type == 4'd15) ||
                         (w_next_mode > r_mode_last);
   assign w_frame_err  = (w_cnt_nxt != expected_count(r_convert_type));

   // NOTE: all state below updates with <= so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cyc          <= '0;
         r_cnt          <= '0;
         r_sum          <= '0;
         r_mode_last    <= '0;
         r_dut_rst_n    <= 1'b0;
         r_convert_type <= 4'd15;
         r_busy         <= 1'b0;
         r_frame_done   <= 1'b0;
         r_frame_mode   <= '0;
         r_frame_count  <= '0;
         r_frame_sum    <= '0;
         r_frame_err    <= 1'b0;
         r_err_total    <= '0;
         r_seq_done     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_seq_done   <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (w_first_eff <= mode_last) begin
                     r_state        <= S_DRST;
                     r_convert_type <= w_first_eff;
                     r_mode_last    <= mode_last;
                     r_err_total    <= '0;
                     r_cyc          <= '0;
                     r_cnt          <= '0;
                     r_sum          <= '0;
                  end else begin
                     r_state    <= S_DONE;
                     r_seq_done <= 1'b1;
                  end
               end
            end
            S_DRST: begin
               if (r_cyc == DRST_LAST) begin
                  r_state     <= S_RUN;
                  r_cyc       <= '0;
                  r_dut_rst_n <= 1'b1;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            S_RUN: begin
               r_cnt <= w_cnt_nxt;
               r_sum <= w_sum_nxt;
               if (r_cyc == RUN_LAST) begin
                  r_state       <= S_REPORT;
                  r_dut_rst_n   <= 1'b0;
                  r_frame_done  <= 1'b1;
                  r_frame_mode  <= r_convert_type;
                  r_frame_count <= w_cnt_nxt;
                  r_frame_sum   <= w_sum_nxt;
                  r_frame_err   <= w_frame_err;
                  if (w_frame_err && r_err_total != 8'hFF) r_err_total <= r_err_total + 8'd1;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            S_REPORT: begin
               if (w_last_frame) begin
                  r_state    <= S_DONE;
                  r_seq_done <= 1'b1;
               end else begin
                  r_state        <= S_DRST;
                  r_convert_type <= w_next_mode;
                  r_cyc          <= '0;
                  r_cnt          <= '0;
                  r_sum          <= '0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dut_rst_n    = r_dut_rst_n;
   assign convert_type = r_convert_type;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign frame_mode   = r_frame_mode;
   assign frame_count  = r_frame_count;
   assign frame_sum    = r_frame_sum;
   assign frame_err    = r_frame_err;
   assign err_total    = r_err_total;
   assign seq_done     = r_seq_done;

endmodule

// File: tb/tb_scale_frame_seq.sv
// Bench for scale_frame_seq: a short-frame instance for sequencing and a long-frame
// instance for the mode-0 count case, checked against a frame-level scoreboard.
module tb_scale_frame_seq;

   localparam int PIX_W = 16;
   localparam int F_S   = 4100;
   localparam int D_S   = 3;
   localparam int F_L   = 36870;
   localparam int D_L   = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [3:0]       mode_first, mode_last;
   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             sel;

   logic        s_dut_rst_n, s_busy, s_frame_done, s_frame_err, s_seq_done;
   logic [3:0]  s_convert_type, s_frame_mode;
   logic [16:0] s_frame_count;
   logic [31:0] s_frame_sum;
   logic [7:0]  s_err_total;
   logic        l_dut_rst_n, l_busy, l_frame_done, l_frame_err, l_seq_done;
   logic [3:0]  l_convert_type, l_frame_mode;
   logic [16:0] l_frame_count;
   logic [31:0] l_frame_sum;
   logic [7:0]  l_err_total;

   logic        dut_rst_n, busy, frame_done, frame_err, seq_done;
   logic [3:0]  convert_type, frame_mode;
   logic [16:0] frame_count;
   logic [31:0] frame_sum;
   logic [7:0]  err_total;

   always #5 clk = ~clk;

   scale_frame_seq #(.PIX_W(PIX_W), .FRAME_CYCLES(F_S), .DUT_RST_CYC(D_S)) u_dut_short (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .mode_first(mode_first),
      .mode_last(mode_last), .pix_data(pix_data), .pix_valid(pix_valid),
      .dut_rst_n(s_dut_rst_n), .convert_type(s_convert_type), .busy(s_busy),
      .frame_done(s_frame_done), .frame_mode(s_frame_mode), .frame_count(s_frame_count),
      .frame_sum(s_frame_sum), .frame_err(s_frame_err), .err_total(s_err_total),
      .seq_done(s_seq_done));

   scale_frame_seq #(.PIX_W(PIX_W), .FRAME_CYCLES(F_L), .DUT_RST_CYC(D_L)) u_dut_long (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .mode_first(mode_first),
      .mode_last(mode_last), .pix_data(pix_data), .pix_valid(pix_valid),
      .dut_rst_n(l_dut_rst_n), .convert_type(l_convert_type), .busy(l_busy),
      .frame_done(l_frame_done), .frame_mode(l_frame_mode), .frame_count(l_frame_count),
      .frame_sum(l_frame_sum), .frame_err(l_frame_err), .err_total(l_err_total),
      .seq_done(l_seq_done));

   assign dut_rst_n    = sel ? l_dut_rst_n    : s_dut_rst_n;
   assign busy         = sel ? l_busy         : s_busy;
   assign frame_done   = sel ? l_frame_done   : s_frame_done;
   assign frame_err    = sel ? l_frame_err    : s_frame_err;
   assign seq_done     = sel ? l_seq_done     : s_seq_done;
   assign convert_type = sel ? l_convert_type : s_convert_type;
   assign frame_mode   = sel ? l_frame_mode   : s_frame_mode;
   assign frame_count  = sel ? l_frame_count  : s_frame_count;
   assign frame_sum    = sel ? l_frame_sum    : s_frame_sum;
   assign err_total    = sel ? l_err_total    : s_err_total;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: what each report must contain, in order.
   typedef struct {
      logic [3:0]  mode;
      logic [16:0] count;
      logic [31:0] sum;
      logic        err;
   } frame_t;

   frame_t exp_q[$];
   frame_t cmp_e;
   frame_t last_e = '{mode: 4'd0, count: 17'd0, sum: 32'd0, err: 1'b0};
   int     exp_err_total  = 0;
   int     frame_done_cnt = 0;
   int     seq_done_cnt   = 0;
   logic   rst_sampled    = 1'b0;

   function automatic int spec_count(input int mode);
      case (mode)
         0:       return 36864;
         1:       return 16384;
         2:       return 9216;
         3:       return 4096;
         default: return 65536;
      endcase
   endfunction

   always @(posedge clk) rst_sampled <= rst_n;

   always @(negedge clk) begin
      if (!rst_sampled) begin
         check("rst_dut_rst_n", dut_rst_n, 0);
         check("rst_convert_type", convert_type, 15);
         check("rst_busy", busy, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_frame_mode", frame_mode, 0);
         check("rst_frame_count", frame_count, 0);
         check("rst_frame_sum", frame_sum, 0);
         check("rst_frame_err", frame_err, 0);
         check("rst_err_total", err_total, 0);
         check("rst_seq_done", seq_done, 0);
         last_e = '{mode: 4'd0, count: 17'd0, sum: 32'd0, err: 1'b0};
         exp_q.delete();
      end else begin
         if (frame_done) begin
            frame_done_cnt++;
            check("frame_done_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               cmp_e  = exp_q.pop_front();
               last_e = cmp_e;
               if (cmp_e.err && exp_err_total < 255) exp_err_total++;
               check("err_total", err_total, exp_err_total);
            end
         end
         check("frame_mode", frame_mode, last_e.mode);
         check("frame_count", frame_count, last_e.count);
         check("frame_sum", frame_sum, last_e.sum);
         check("frame_err", frame_err, last_e.err);
         check("run_without_busy", 32'(dut_rst_n && !busy), 0);
         if (seq_done) begin
            seq_done_cnt++;
            check("frames_pending_at_seq_done", exp_q.size(), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits out DRST, then drives one RUN window and records the expected report.
   task automatic run_frame(input logic [3:0] mode, input int lat_exp, input int nbeats,
                            input logic [PIX_W-1:0] d0, input bit incr,
                            input bit valid_out, input bit poke);
      int          lat  = 0;
      int          run  = 0;
      int          flim = sel ? F_L : F_S;
      logic [31:0] sum  = 0;
      logic [PIX_W-1:0] d;
      frame_t      e;
      while (!dut_rst_n && lat < 200) begin
         tick();
         lat++;
      end
      check("drst_length", lat, lat_exp);
      check("convert_type", convert_type, mode);
      for (int i = 0; i < nbeats; i++) begin
         d   = incr ? d0 + PIX_W'(i) : d0;
         sum = sum + 32'(d);
      end
      e.mode  = mode;
      e.count = 17'(nbeats);
      e.sum   = sum;
      e.err   = (nbeats != spec_count(int'(mode)));
      exp_q.push_back(e);
      do begin
         pix_valid = (run < nbeats);
         pix_data  = incr ? d0 + PIX_W'(run) : d0;
         if (poke && run == 1000) begin
            start      = 1'b1;
            mode_first = 4'd0;
            mode_last  = 4'd0;
         end else begin
            start = 1'b0;
         end
         tick();
         run++;
      end while (dut_rst_n && run < flim + 50);
      pix_valid = valid_out;
      start     = 1'b0;
      check("run_length", run, flim);
      check("frame_done_at_report", frame_done, 1);
   endtask

   task automatic run_seq(input logic [3:0] first, input logic [3:0] last, input int nbeats,
                          input logic [PIX_W-1:0] d0, input bit incr,
                          input bit valid_out, input bit poke);
      logic [3:0] ml[$];
      int fd0  = frame_done_cnt;
      int dlen = sel ? D_L : D_S;
      for (int m = int'(first); m <= int'(last); m++)
         if (m < 8 || m > 14) ml.push_back(4'(m));
      if (ml.size() > 0) exp_err_total = 0;
      mode_first = first;
      mode_last  = last;
      pix_valid  = valid_out;
      start      = 1'b1;
      tick();
      start = 1'b0;
      foreach (ml[k])
         run_frame(ml[k], (k == 0) ? dlen : dlen + 1, nbeats, d0, incr, valid_out, poke && k == 0);
      if (ml.size() > 0) tick();
      check("seq_done_pulse", seq_done, 1);
      check("busy_in_done", busy, 1);
      check("frame_done_count", frame_done_cnt - fd0, ml.size());
      tick();
      check("seq_done_width", seq_done, 0);
      check("busy_back_idle", busy, 0);
      pix_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0, sd0, lat;
      rst_n = 1'b0; start = 1'b0; mode_first = '0; mode_last = '0;
      pix_data = '0; pix_valid = 1'b0; sel = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Mode 3 with exact beat count; a second start mid-RUN must be ignored.
      run_seq(4'd3, 4'd3, 4096, 16'h0002, 1'b0, 1'b0, 1'b1);
      check("t1_count_literal", frame_count, 17'd4096);
      check("t1_sum_literal", frame_sum, 32'h0000_2000);
      check("t1_err_literal", frame_err, 0);
      check("t1_err_total_literal", err_total, 0);

      // Reversed range: straight to DONE.
      run_seq(4'd5, 4'd2, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // 6..15 runs 6, 7, 15.
      run_seq(4'd6, 4'd15, 4000, 16'h1234, 1'b0, 1'b0, 1'b0);
      check("t3_err_total_literal", err_total, 3);
      check("t3_last_mode_literal", frame_mode, 15);

      // Wrapping ramp data over modes 2..3.
      run_seq(4'd2, 4'd3, 4096, 16'hFFF0, 1'b1, 1'b0, 1'b0);
      check("t4_sum_literal", frame_sum, 32'h008E_F800);
      check("t4_err_total_literal", err_total, 1);

      // Range entirely inside the reserved modes.
      run_seq(4'd9, 4'd12, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // pix_valid held high outside RUN must not be counted.
      run_seq(4'd3, 4'd3, 4096, 16'h0002, 1'b0, 1'b1, 1'b0);
      check("t6_count_literal", frame_count, 17'd4096);

      // Reset in the middle of RUN.
      fd0 = frame_done_cnt;
      sd0 = seq_done_cnt;
      mode_first = 4'd3; mode_last = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!dut_rst_n && lat < 200) begin
         tick();
         lat++;
      end
      check("t7_entered_run", dut_rst_n, 1);
      pix_valid = 1'b1;
      repeat (100) tick();
      rst_n = 1'b0;
      tick();
      check("t7_busy", busy, 0);
      check("t7_dut_rst_n", dut_rst_n, 0);
      check("t7_convert_type", convert_type, 15);
      check("t7_frame_done", frame_done, 0);
      rst_n = 1'b1;
      pix_valid = 1'b0;
      repeat (200) tick();
      check("t7_no_frame_done", frame_done_cnt - fd0, 0);
      check("t7_no_seq_done", seq_done_cnt - sd0, 0);
      check("t7_still_idle", busy, 0);

      // Long-frame instance: mode 0 one beat short.
      sel = 1'b1;
      tick();
      run_seq(4'd0, 4'd0, 36863, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("t8_count_literal", frame_count, 17'd36863);
      check("t8_sum_literal", frame_sum, 32'd36863);
      check("t8_err_literal", frame_err, 1);
      check("t8_err_total_literal", err_total, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scale_frame_seq.md
SCALE_FRAME_SEQ -- requirements
Module: scale_frame_seq

Interface
REQ-001 SHALL have parameter PIX_W, default 16, pixel data width.
REQ-002 SHALL have parameter FRAME_CYCLES, default 65536, RUN-state length per frame in cycles (legal range 1..131071).
REQ-003 SHALL have parameter DUT_RST_CYC, default 4, scaler-reset hold length in cycles (>=1).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin sequence; sampled in IDLE only.
- mode_first  in  4  first convert type of sequence.
- mode_last  in  4  last convert type of sequence.
- pix_data  in  PIX_W  scaler output pixel.
- pix_valid  in  1  scaler write enable.
- dut_rst_n  out  1  scaler reset, active low.
- convert_type  out  4  mode driven to scaler.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_mode  out  4  mode of last reported frame.
- frame_count  out  17  pixels accepted in last frame.
- frame_sum  out  32  checksum of last frame.
- frame_err  out  1  last frame count mismatch.
- err_total  out  8  mismatched frames in sequence, saturating.
- seq_done  out  1  one-cycle pulse at sequence end.

Function
REQ-005 SHALL implement FSM states IDLE, DRST, RUN, REPORT, DONE.
REQ-006 IDLE + start, mode_first <= mode_last: next state DRST, convert_type <= mode_first, err_total <= 0.
REQ-007 IDLE + start, mode_first > mode_last: next state DONE, no frame run.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 DRST SHALL last exactly DUT_RST_CYC cycles with dut_rst_n=0, then enter RUN; frame counter and sum cleared on DRST entry.
REQ-010 RUN SHALL last exactly FRAME_CYCLES cycles with dut_rst_n=1; dut_rst_n=0 in all other states.
REQ-011 In RUN, each cycle with pix_valid=1: count += 1 (saturate at 131071), sum = (sum + zero-extended pix_data) mod 2^32.
REQ-012 pix_valid outside RUN SHALL be ignored.
REQ-013 REPORT SHALL last one cycle: frame_done=1; frame_mode, frame_count, frame_sum, frame_err registered on REPORT entry and held until next REPORT.
REQ-014 Expected count: mode 0 -> 36864, 1 -> 16384, 2 -> 9216, 3 -> 4096, 4..7 and 15 -> 65536.
REQ-015 frame_err SHALL be 1 iff frame_count != expected; on error err_total += 1, saturating at 255.
REQ-016 After REPORT: if convert_type == mode_last go to DONE; else convert_type <= next mode above current, skipping 8..14, and go to DRST.
REQ-017 mode_first/mode_last SHALL be latched at start; later changes have no effect on the running sequence.
REQ-018 Sequence endpoints in 8..14 SHALL be skipped (no frame run for them).
REQ-019 DONE SHALL last one cycle with seq_done=1, then IDLE.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-RUN, with no frame_done or seq_done pulse.
REQ-022 Reset values: dut_rst_n=0, convert_type=15, busy=0, frame_done=0, frame_mode=0, frame_count=0, frame_sum=0, frame_err=0, err_total=0, seq_done=0.

Verification
REQ-023 start, modes 3..3, 4096 valid beats of data 0x0002 in RUN -> one frame_done, frame_count=4096, frame_sum=0x2000, frame_err=0, seq_done one cycle after REPORT.
REQ-024 modes 0..0, 36863 valid beats of data 0x0001 -> frame_count=36863, frame_sum=36863, frame_err=1, err_total=1.
REQ-025 modes 6..15 -> convert_type sequence 6, 7, 15; three frame_done pulses; each frame has DUT_RST_CYC cycles of dut_rst_n=0 before RUN.
REQ-026 rst_n low mid-RUN -> next edge: IDLE, busy=0, dut_rst_n=0, convert_type=15, no frame_done.
REQ-027 mode_first=5, mode_last=2 -> seq_done the cycle after start sampled, no frame_done; start during RUN -> ignored.
REQ-028 pix_valid=1 throughout DRST and REPORT, 4096 beats in RUN, mode 3 -> frame_count=4096 exactly.
